xslideaccum_mc: RTL and testbench

XSLIDEACCUM_MC -- requirements
Module: xslideaccum_mc

---
 rtl/xtool_pkg.sv | 26 ++
 rtl/xslideaccum_mc_if.sv | 26 ++
 rtl/xslideaccum_ram.sv | 20 ++
 rtl/xslideaccum_mc.sv | 103 ++++++++++
 tb/tb_xslideaccum_mc.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/xtool_pkg.sv
// xtool_pkg: shared width helpers for the sliding accumulator slice
// clog2/flog2 are ceiling/floor log2; cw/ww/ow derive the channel, window and sum widths
package xtool_pkg;
  localparam int BWID_DEF = 16;
  localparam int MAXWIN_DEF = 64;
  localparam int NCH_DEF = 4;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int flog2(input logic [31:0] n);
    int r = 0;
    for (int i = 0; i < 32; i++) if (n[i]) r = i;
    return r;
  endfunction
  function automatic int cw(input int nch);
    return nch > 1 ? clog2(nch) : 1;
  endfunction
  function automatic int ww(input int maxwin);
    return clog2(maxwin) + 1;
  endfunction
  function automatic int ow(input int bwid, input int maxwin);
    return bwid + clog2(maxwin);
  endfunction
endpackage

// File: rtl/xslideaccum_mc_if.sv
// xslideaccum_mc_if: sample/result bus of the sliding accumulator
// master drives iv_data, i_ch, i_nd, iv_win, i_win_ld; slave drives ov_data, ov_ch, o_dv, o_full
// XSLIDEACCUM_MC_MEAN_EN adds ov_mean (slave output)
interface xslideaccum_mc_if import xtool_pkg::*; #(
  parameter int BWID = BWID_DEF,
  parameter int MAXWIN = MAXWIN_DEF,
  parameter int NCH = NCH_DEF
);
  logic [BWID-1:0] iv_data;
  logic [cw(NCH)-1:0] i_ch;
  logic i_nd;
  logic [ww(MAXWIN)-1:0] iv_win;
  logic i_win_ld;
  logic [ow(BWID, MAXWIN)-1:0] ov_data;
  logic [cw(NCH)-1:0] ov_ch;
  logic o_dv;
  logic o_full;
`ifdef XSLIDEACCUM_MC_MEAN_EN
  logic [BWID-1:0] ov_mean;
  modport master (output iv_data, i_ch, i_nd, iv_win, i_win_ld, input ov_data, ov_ch, o_dv, o_full, ov_mean);
  modport slave (input iv_data, i_ch, i_nd, iv_win, i_win_ld, output ov_data, ov_ch, o_dv, o_full, ov_mean);
`else
  modport master (output iv_data, i_ch, i_nd, iv_win, i_win_ld, input ov_data, ov_ch, o_dv, o_full);
  modport slave (input iv_data, i_ch, i_nd, iv_win, i_win_ld, output ov_data, ov_ch, o_dv, o_full);
`endif
endinterface

// File: rtl/xslideaccum_ram.sv
// xslideaccum_ram: simple dual-port read-first history memory, 1-clk read latency
// clk; we/waddr/wdata write port; raddr/rdata read port (same-address read returns the old word)
module xslideaccum_ram #(
  parameter int DW = 16,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: rtl/xslideaccum_mc.sv
// xslideaccum_mc: time-interleaved per-channel sliding-window sum, 2-clk latency, 1 sample/clk
// clk, rst : clock and synchronous active-high reset (behaves as a window load of MAXWIN)
// bus      : xslideaccum_mc_if.slave, samples/window load in, window sums out
// XSLIDEACCUM_MC_MEAN_EN adds bus.ov_mean = window sum shifted right by floor(log2(WIN))
module xslideaccum_mc import xtool_pkg::*; #(
  parameter int BWID = BWID_DEF,
  parameter int MAXWIN = MAXWIN_DEF,
  parameter int NCH = NCH_DEF,
  parameter int SIGNED = 1
) (
  input logic clk,
  input logic rst,
  xslideaccum_mc_if.slave bus
);
  localparam int CW = cw(NCH);
  localparam int WW = ww(MAXWIN);
  localparam int OW = ow(BWID, MAXWIN);
  localparam int PW = clog2(MAXWIN);
  localparam int AW = clog2(NCH) + PW;
  localparam int NS = 2 ** CW;
  logic clr, nd;
  logic [CW-1:0] ch, s1_ch, out_ch;
  logic [WW-1:0] win, win_req, fill_c, fill_n;
  logic [WW-1:0] fill [NS];
  logic [PW-1:0] ptr [NS];
  logic [PW-1:0] ptr_c, ptr_n;
  logic [OW-1:0] sum [NS];
  logic [OW-1:0] sum_n, out_data;
  logic [BWID-1:0] s1_new, rdata, old;
  logic [AW-1:0] addr;
  logic s1_v, s1_old_ok, s1_full, out_dv, out_full;
  logic signed [BWID:0] diff;
  function automatic logic [BWID:0] ext(input logic [BWID-1:0] x);
    return SIGNED != 0 ? {x[BWID-1], x} : {1'b0, x};
  endfunction
  // The slot under the pointer holds the sample leaving the window; until the
  // channel has seen WIN samples that slot is stale and counts as zero.
  always_comb begin
    clr = rst | bus.i_win_ld;
    nd = bus.i_nd & ~clr;
    ch = NCH > 1 ? bus.i_ch : '0;
    win_req = rst ? WW'(MAXWIN) : bus.iv_win == '0 ? WW'(1) : bus.iv_win > WW'(MAXWIN) ? WW'(MAXWIN) : bus.iv_win;
    ptr_c = ptr[ch];
    fill_c = fill[ch];
    ptr_n = WW'(ptr_c) == win - WW'(1) ? '0 : ptr_c + 1'b1;
    fill_n = fill_c == win ? fill_c : fill_c + 1'b1;
    addr = AW'({ch, ptr_c});
    old = s1_old_ok ? rdata : '0;
    diff = ext(s1_new) - ext(old);
    sum_n = sum[s1_ch] + OW'(diff);
  end
  xslideaccum_ram #(.DW(BWID), .DEPTH(NCH * MAXWIN), .AW(AW)) u_ram (
    .clk(clk),
    .we(nd),
    .waddr(addr),
    .wdata(bus.iv_data),
    .raddr(addr),
    .rdata(rdata)
  );
  // Pointer/fill advance at issue and the sum updates in a single cycle at
  // completion, so same-channel back-to-back samples always see fresh state.
  always_ff @(posedge clk) begin
    if (clr) begin
      win <= win_req;
      for (int i = 0; i < NS; i++) begin
        ptr[i] <= '0;
        fill[i] <= '0;
        sum[i] <= '0;
      end
      s1_v <= 1'b0;
      out_dv <= 1'b0;
      if (rst) begin
        out_data <= '0;
        out_ch <= '0;
        out_full <= 1'b0;
      end
    end else begin
      s1_v <= nd;
      out_dv <= s1_v;
      if (nd) begin
        ptr[ch] <= ptr_n;
        fill[ch] <= fill_n;
        s1_ch <= ch;
        s1_new <= bus.iv_data;
        s1_old_ok <= fill_c == win;
        s1_full <= fill_n == win;
      end
      if (s1_v) begin
        sum[s1_ch] <= sum_n;
        out_data <= sum_n;
        out_ch <= s1_ch;
        out_full <= s1_full;
      end
    end
  end
  assign bus.ov_data = out_data;
  assign bus.ov_ch = out_ch;
  assign bus.o_dv = out_dv;
  assign bus.o_full = out_full;
`ifdef XSLIDEACCUM_MC_MEAN_EN
  assign bus.ov_mean = BWID'(SIGNED != 0 ? $unsigned($signed(out_data) >>> flog2(32'(win))) : out_data >> flog2(32'(win)));
`endif
endmodule

// File: tb/tb_xslideaccum_mc.sv
// tb_xslideaccum_mc: directed self-checking bench for xslideaccum_mc (default parameters)
module tb_xslideaccum_mc;
  localparam int OW = 22;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  xslideaccum_mc_if #(.BWID(16), .MAXWIN(64), .NCH(4)) bus ();
  xslideaccum_mc #(.BWID(16), .MAXWIN(64), .NCH(4), .SIGNED(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic tick(input logic nd, input logic [1:0] ch, input logic [15:0] d);
    bus.i_nd = nd;
    bus.i_ch = ch;
    bus.iv_data = d;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [6:0] w);
    bus.i_win_ld = 1'b1;
    bus.iv_win = w;
    tick(1'b0, 2'd0, 16'd0);
    bus.i_win_ld = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick(1'b0, 2'd0, 16'd0);
    tick(1'b1, 2'd2, 16'h1234);
    rst = 1'b0;
    checks++;
    if ({bus.o_dv, bus.o_full, bus.ov_ch, bus.ov_data} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state: dv=%b full=%b ch=%0d data=%0h, required all zero", bus.o_dv, bus.o_full, bus.ov_ch, bus.ov_data);
    end
    tick(1'b0, 2'd0, 16'd0);
    checks++;
    if (bus.o_dv !== 1'b0) begin
      errors++;
      $display("FAIL reset_drop: dv=%b, required 0", bus.o_dv);
    end
  endtask
  task automatic test_window4;
    int e [6] = '{1, 3, 6, 10, 14, 18};
    load(7'd4);
    tick(1'b1, 2'd0, 16'd1);
    checks++;
    if (bus.o_dv !== 1'b0) begin
      errors++;
      $display("FAIL w4_first: dv=%b, required 0", bus.o_dv);
    end
    for (int i = 1; i <= 6; i++) begin
      tick(i < 6, 2'd0, 16'(i + 1));
      checks++;
      if ({bus.o_dv, bus.o_full, bus.ov_data} !== {1'b1, i >= 4, OW'(e[i-1])}) begin
        errors++;
        $display("FAIL w4_out%0d: dv=%b full=%b data=%0d, required dv=1 full=%b data=%0d", i, bus.o_dv, bus.o_full, bus.ov_data, i >= 4, e[i-1]);
      end
    end
    tick(1'b0, 2'd0, 16'd0);
    checks++;
    if ({bus.o_dv, bus.o_full, bus.ov_data} !== {1'b0, 1'b1, OW'(18)}) begin
      errors++;
      $display("FAIL w4_hold: dv=%b full=%b data=%0d, required dv=0 full=1 data=18", bus.o_dv, bus.o_full, bus.ov_data);
    end
  endtask
  task automatic test_signed;
    logic [15:0] d [3] = '{16'h8000, 16'h8000, 16'h7FFF};
    int e [3] = '{-32768, -65536, -1};
    load(7'd2);
    for (int i = 0; i <= 3; i++) begin
      tick(i < 3, 2'd1, i < 3 ? d[i] : 16'd0);
      if (i >= 1) begin
        checks++;
        if ({bus.o_dv, bus.ov_ch, bus.ov_data} !== {1'b1, 2'd1, OW'(e[i-1])}) begin
          errors++;
          $display("FAIL signed_out%0d: dv=%b ch=%0d data=%0h, required dv=1 ch=1 data=%0h", i, bus.o_dv, bus.ov_ch, bus.ov_data, OW'(e[i-1]));
        end
      end
    end
  endtask
  task automatic test_interleave;
    int j, k, n, e;
    load(7'd8);
    for (int i = 0; i <= 40; i++) begin
      tick(i < 40, 2'(i % 4), 16'((i % 4) + 1));
      if (i >= 1) begin
        j = i - 1;
        k = j % 4;
        n = j / 4 + 1;
        e = (n < 8 ? n : 8) * (k + 1);
        checks++;
        if ({bus.o_dv, bus.ov_ch, bus.o_full, bus.ov_data} !== {1'b1, 2'(k), n >= 8, OW'(e)}) begin
          errors++;
          $display("FAIL ilv_out%0d: dv=%b ch=%0d full=%b data=%0d, required dv=1 ch=%0d full=%b data=%0d", j, bus.o_dv, bus.ov_ch, bus.o_full, bus.ov_data, k, n >= 8, e);
        end
      end
    end
  endtask
  task automatic test_back_to_back;
    int e [5] = '{10, 30, 60, 90, 120};
    load(7'd3);
    for (int i = 0; i <= 5; i++) begin
      tick(i < 5, 2'd2, 16'(10 * (i + 1)));
      if (i >= 1) begin
        checks++;
        if ({bus.o_dv, bus.ov_ch, bus.o_full, bus.ov_data} !== {1'b1, 2'd2, i >= 3, OW'(e[i-1])}) begin
          errors++;
          $display("FAIL b2b_out%0d: dv=%b ch=%0d full=%b data=%0d, required dv=1 ch=2 full=%b data=%0d", i, bus.o_dv, bus.ov_ch, bus.o_full, bus.ov_data, i >= 3, e[i-1]);
        end
      end
    end
  endtask
  task automatic test_win_ld_midstream;
    tick(1'b1, 2'd0, 16'd5);
    tick(1'b1, 2'd0, 16'd6);
    bus.i_win_ld = 1'b1;
    bus.iv_win = 7'd0;
    tick(1'b1, 2'd0, 16'd99);
    bus.i_win_ld = 1'b0;
    checks++;
    if (bus.o_dv !== 1'b0) begin
      errors++;
      $display("FAIL wl_cut1: dv=%b, required 0", bus.o_dv);
    end
    tick(1'b1, 2'd0, 16'd11);
    checks++;
    if (bus.o_dv !== 1'b0) begin
      errors++;
      $display("FAIL wl_cut2: dv=%b, required 0", bus.o_dv);
    end
    tick(1'b1, 2'd0, 16'd12);
    checks++;
    if ({bus.o_dv, bus.o_full, bus.ov_data} !== {1'b1, 1'b1, OW'(11)}) begin
      errors++;
      $display("FAIL wl_w1a: dv=%b full=%b data=%0d, required dv=1 full=1 data=11", bus.o_dv, bus.o_full, bus.ov_data);
    end
    tick(1'b1, 2'd0, 16'hFFFD);
    checks++;
    if ({bus.o_dv, bus.ov_data} !== {1'b1, OW'(12)}) begin
      errors++;
      $display("FAIL wl_w1b: dv=%b data=%0d, required dv=1 data=12", bus.o_dv, bus.ov_data);
    end
    tick(1'b0, 2'd0, 16'd0);
    checks++;
    if ({bus.o_dv, bus.ov_data} !== {1'b1, OW'(-3)}) begin
      errors++;
      $display("FAIL wl_w1c: dv=%b data=%0h, required dv=1 data=%0h", bus.o_dv, bus.ov_data, OW'(-3));
    end
    tick(1'b0, 2'd0, 16'd0);
    checks++;
    if (bus.o_dv !== 1'b0) begin
      errors++;
      $display("FAIL wl_idle: dv=%b, required 0", bus.o_dv);
    end
  endtask
  task automatic test_rst_midstream;
    load(7'd4);
    tick(1'b1, 2'd3, 16'd1);
    tick(1'b1, 2'd3, 16'd2);
    tick(1'b1, 2'd3, 16'd3);
    rst = 1'b1;
    tick(1'b1, 2'd3, 16'd50);
    rst = 1'b0;
    checks++;
    if ({bus.o_dv, bus.o_full, bus.ov_ch, bus.ov_data} !== 26'd0) begin
      errors++;
      $display("FAIL rst_mid: dv=%b full=%b ch=%0d data=%0d, required all zero", bus.o_dv, bus.o_full, bus.ov_ch, bus.ov_data);
    end
    tick(1'b1, 2'd3, 16'd7);
    checks++;
    if (bus.o_dv !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush: dv=%b, required 0", bus.o_dv);
    end
    tick(1'b0, 2'd0, 16'd0);
    checks++;
    if ({bus.o_dv, bus.ov_ch, bus.o_full, bus.ov_data} !== {1'b1, 2'd3, 1'b0, OW'(7)}) begin
      errors++;
      $display("FAIL rst_after: dv=%b ch=%0d full=%b data=%0d, required dv=1 ch=3 full=0 data=7", bus.o_dv, bus.ov_ch, bus.o_full, bus.ov_data);
    end
  endtask
  initial begin
    bus.iv_data = '0;
    bus.i_ch = '0;
    bus.i_nd = 1'b0;
    bus.iv_win = '0;
    bus.i_win_ld = 1'b0;
    test_reset();
    test_window4();
    test_signed();
    test_interleave();
    test_back_to_back();
    test_win_ld_midstream();
    test_rst_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at 100000, required finish");
    $fatal(1);
  end
endmodule
